// File: rtl/apb_cmd_master.sv
// ----------------------------------------------------------------------------
// apb_cmd_master
// APB3 initiator. Accepts one command at a time on a valid/ready stream,
// runs a single SETUP/ACCESS transfer on the peripheral bus and returns the
// read data and status on a valid/ready response stream.
//
// Optional build macro: APB_TIMEOUT_EN
//   defined   - an ACCESS phase that waits TIMEOUT_CYCLES cycles without
//               PREADY is abandoned and reported with RSP_ERR=1, RSP_TIMEOUT=1.
//   undefined - ACCESS waits for PREADY indefinitely; RSP_TIMEOUT stays 0.
//
// Reset (PRESET) is synchronous and active-high. Every output except
// CMD_READY comes straight from a flop.
// ----------------------------------------------------------------------------
module apb_cmd_master #(
  parameter int ADDR_WIDTH     = 12,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  // command stream
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic                  CMD_WRITE,
  input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
  input  logic [31:0]           CMD_WDATA,
  // response stream
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [31:0]           RSP_RDATA,
  output logic                  RSP_ERR,
  output logic                  RSP_TIMEOUT,
  output logic                  BUSY,
  // APB3 initiator side
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]           PWDATA,
  input  logic [31:0]           PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Word-aligns the byte address: the two low address bits are never driven.
  localparam logic [ADDR_WIDTH-1:0] ADDR_ALIGN_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

  state_t                  state_r;
  logic                    psel_r;
  logic                    penable_r;
  logic                    pwrite_r;
  logic [ADDR_WIDTH-1:0]   paddr_r;
  logic [31:0]             pwdata_r;
  logic                    rsp_valid_r;
  logic [31:0]             rsp_rdata_r;
  logic                    rsp_err_r;
  logic                    rsp_timeout_r;
  logic                    busy_r;
  logic                    to_hit_s;

  // Command side is only open in IDLE, and never while reset is asserted.
  assign CMD_READY = (state_r == ST_IDLE) && !PRESET;

  assign PSEL        = psel_r;
  assign PENABLE     = penable_r;
  assign PWRITE      = pwrite_r;
  assign PADDR       = paddr_r;
  assign PWDATA      = pwdata_r;
  assign RSP_VALID   = rsp_valid_r;
  assign RSP_RDATA   = rsp_rdata_r;
  assign RSP_ERR     = rsp_err_r;
  assign RSP_TIMEOUT = rsp_timeout_r;
  assign BUSY        = busy_r;

`ifdef APB_TIMEOUT_EN
  // One extra bit so the counter can step past the terminal value harmlessly.
  localparam int              TO_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_r;

  // Counts ACCESS cycles spent waiting on PREADY; restarted for every transfer.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      to_cnt_r <= {TO_W{1'b0}};
    end else if (state_r == ST_SETUP) begin
      to_cnt_r <= {TO_W{1'b0}};
    end else if ((state_r == ST_ACCESS) && !PREADY) begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end else begin
      to_cnt_r <= to_cnt_r;
    end
  end

  // Last permitted wait cycle; PREADY in this same cycle still completes normally.
  assign to_hit_s = (state_r == ST_ACCESS) && (to_cnt_r == TO_LAST);
`else
  // No watchdog: ACCESS can only be left through PREADY.
  assign to_hit_s = 1'b0;

  logic unused_cfg_s;
  assign unused_cfg_s = (TIMEOUT_CYCLES >= 2);
`endif

  // Transfer sequencer: IDLE -> SETUP -> ACCESS -> RESP, all bus and response outputs registered.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_r       <= ST_IDLE;
      psel_r        <= 1'b0;
      penable_r     <= 1'b0;
      pwrite_r      <= 1'b0;
      paddr_r       <= {ADDR_WIDTH{1'b0}};
      pwdata_r      <= 32'h0000_0000;
      rsp_valid_r   <= 1'b0;
      rsp_rdata_r   <= 32'h0000_0000;
      rsp_err_r     <= 1'b0;
      rsp_timeout_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (CMD_VALID) begin
            // Capture the command; the bus address is frozen from here to completion.
            pwrite_r <= CMD_WRITE;
            paddr_r  <= CMD_ADDR & ADDR_ALIGN_MASK;
            pwdata_r <= CMD_WDATA;
            psel_r   <= 1'b1;
            busy_r   <= 1'b1;
            state_r  <= ST_SETUP;
          end else begin
            state_r  <= ST_IDLE;
          end
        end

        ST_SETUP: begin
          penable_r <= 1'b1;
          state_r   <= ST_ACCESS;
        end

        ST_ACCESS: begin
          if (PREADY) begin
            // PSLVERR only counts together with PREADY; read data is kept even on error.
            rsp_rdata_r   <= pwrite_r ? 32'h0000_0000 : PRDATA;
            rsp_err_r     <= PSLVERR;
            rsp_timeout_r <= 1'b0;
            psel_r        <= 1'b0;
            penable_r     <= 1'b0;
            rsp_valid_r   <= 1'b1;
            state_r       <= ST_RESP;
          end else if (to_hit_s) begin
            // Slave never answered: drop the bus and report a timed-out error.
            rsp_rdata_r   <= 32'h0000_0000;
            rsp_err_r     <= 1'b1;
            rsp_timeout_r <= 1'b1;
            psel_r        <= 1'b0;
            penable_r     <= 1'b0;
            rsp_valid_r   <= 1'b1;
            state_r       <= ST_RESP;
          end else begin
            state_r       <= ST_ACCESS;
          end
        end

        ST_RESP: begin
          if (RSP_READY) begin
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r     <= ST_RESP;
          end
        end

        default: begin
          // Unreachable encoding: park the bus and return to a clean IDLE.
          psel_r      <= 1'b0;
          penable_r   <= 1'b0;
          rsp_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// ----------------------------------------------------------------------------
// tb_apb_cmd_master
// Directed bench for apb_cmd_master. The APB slave is played directly by the
// stimulus (PREADY/PRDATA/PSLVERR driven per test). Outputs are sampled 1 ns
// after the rising edge. Build with APB_TIMEOUT_EN to add the watchdog cases.
// ----------------------------------------------------------------------------
module tb_apb_cmd_master;

`ifdef APB_TIMEOUT_EN
  localparam int TB_TO = 8;
`else
  localparam int TB_TO = 256;
`endif

  logic        PCLK;
  logic        PRESET;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic        CMD_WRITE;
  logic [11:0] CMD_ADDR;
  logic [31:0] CMD_WDATA;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;
  logic        RSP_TIMEOUT;
  logic        BUSY;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int n_total;
  int n_bad;

  apb_cmd_master #(
    .ADDR_WIDTH     (12),
    .TIMEOUT_CYCLES (TB_TO)
  ) dut (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .CMD_VALID   (CMD_VALID),
    .CMD_READY   (CMD_READY),
    .CMD_WRITE   (CMD_WRITE),
    .CMD_ADDR    (CMD_ADDR),
    .CMD_WDATA   (CMD_WDATA),
    .RSP_VALID   (RSP_VALID),
    .RSP_READY   (RSP_READY),
    .RSP_RDATA   (RSP_RDATA),
    .RSP_ERR     (RSP_ERR),
    .RSP_TIMEOUT (RSP_TIMEOUT),
    .BUSY        (BUSY),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR)
  );

  // Free-running 100 MHz clock.
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    if (obs !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  // Offer a command in IDLE; returns after the accepting edge.
  task automatic send_cmd(input logic w, input logic [11:0] a, input logic [31:0] d);
    CMD_VALID = 1'b1;
    CMD_WRITE = w;
    CMD_ADDR  = a;
    CMD_WDATA = d;
    #1;
    chk("cmd_ready_idle", {31'd0, CMD_READY}, 32'd1);
    tick;
    CMD_VALID = 1'b0;
  endtask

  // SETUP cycle contents, then advance into ACCESS.
  task automatic chk_setup(input logic w, input logic [11:0] a, input logic [31:0] d);
    chk("setup_psel",    {31'd0, PSEL},    32'd1);
    chk("setup_penable", {31'd0, PENABLE}, 32'd0);
    chk("setup_pwrite",  {31'd0, PWRITE},  {31'd0, w});
    chk("setup_paddr",   {20'd0, PADDR},   {20'd0, a});
    chk("setup_pwdata",  PWDATA,           d);
    chk("setup_busy",    {31'd0, BUSY},    32'd1);
    chk("setup_cmdrdy",  {31'd0, CMD_READY}, 32'd0);
    tick;
  endtask

  // Check a pending response, consume it, and confirm return to IDLE.
  task automatic take_rsp(input logic [31:0] rd, input logic err, input logic to);
    chk("rsp_valid",   {31'd0, RSP_VALID},   32'd1);
    chk("rsp_rdata",   RSP_RDATA,            rd);
    chk("rsp_err",     {31'd0, RSP_ERR},     {31'd0, err});
    chk("rsp_timeout", {31'd0, RSP_TIMEOUT}, {31'd0, to});
    chk("rsp_psel",    {31'd0, PSEL},        32'd0);
    chk("rsp_penable", {31'd0, PENABLE},     32'd0);
    RSP_READY = 1'b1;
    tick;
    RSP_READY = 1'b0;
    chk("post_rsp_valid", {31'd0, RSP_VALID}, 32'd0);
    chk("post_rsp_busy",  {31'd0, BUSY},      32'd0);
  endtask

  initial begin
    n_total   = 0;
    n_bad     = 0;
    PRESET    = 1'b1;
    CMD_VALID = 1'b0;
    CMD_WRITE = 1'b0;
    CMD_ADDR  = 12'h000;
    CMD_WDATA = 32'h0000_0000;
    RSP_READY = 1'b0;
    PRDATA    = 32'h0000_0000;
    PREADY    = 1'b1;
    PSLVERR   = 1'b0;

    // ---- reset values ----
    tick;
    tick;
    chk("rst_psel",      {31'd0, PSEL},        32'd0);
    chk("rst_penable",   {31'd0, PENABLE},     32'd0);
    chk("rst_pwrite",    {31'd0, PWRITE},      32'd0);
    chk("rst_paddr",     {20'd0, PADDR},       32'd0);
    chk("rst_pwdata",    PWDATA,               32'd0);
    chk("rst_rsp_valid", {31'd0, RSP_VALID},   32'd0);
    chk("rst_rsp_rdata", RSP_RDATA,            32'd0);
    chk("rst_rsp_err",   {31'd0, RSP_ERR},     32'd0);
    chk("rst_rsp_to",    {31'd0, RSP_TIMEOUT}, 32'd0);
    chk("rst_busy",      {31'd0, BUSY},        32'd0);
    chk("rst_cmdrdy",    {31'd0, CMD_READY},   32'd0);
    PRESET = 1'b0;
    #1;
    chk("idle_cmdrdy", {31'd0, CMD_READY}, 32'd1);

    // ---- zero-wait write: PSEL N+1, PENABLE N+2, RSP_VALID N+3 ----
    PREADY = 1'b1;
    send_cmd(1'b1, 12'h004, 32'h0000_003C);
    chk_setup(1'b1, 12'h004, 32'h0000_003C);
    chk("wr_acc_psel",    {31'd0, PSEL},      32'd1);
    chk("wr_acc_penable", {31'd0, PENABLE},   32'd1);
    chk("wr_acc_rspv",    {31'd0, RSP_VALID}, 32'd0);
    tick;
    take_rsp(32'h0000_0000, 1'b0, 1'b0);

    // ---- unaligned read, 3 wait states ----
    PREADY = 1'b0;
    PRDATA = 32'h1234_5678;
    send_cmd(1'b0, 12'h003, 32'hFFFF_FFFF);
    chk_setup(1'b0, 12'h000, 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) begin
      chk("rd_wait_psel",    {31'd0, PSEL},      32'd1);
      chk("rd_wait_penable", {31'd0, PENABLE},   32'd1);
      chk("rd_wait_paddr",   {20'd0, PADDR},     32'd0);
      chk("rd_wait_pwrite",  {31'd0, PWRITE},    32'd0);
      chk("rd_wait_rspv",    {31'd0, RSP_VALID}, 32'd0);
      if (i == 3) PREADY = 1'b1;
      tick;
    end
    take_rsp(32'h1234_5678, 1'b0, 1'b0);

    // ---- read with PSLVERR alongside PREADY (after waits with PSLVERR noise) ----
    PREADY  = 1'b0;
    PSLVERR = 1'b1;
    PRDATA  = 32'hDEAD_BEEF;
    send_cmd(1'b0, 12'h100, 32'h0000_0000);
    chk_setup(1'b0, 12'h100, 32'h0000_0000);
    tick;
    PREADY = 1'b1;
    tick;
    take_rsp(32'hDEAD_BEEF, 1'b1, 1'b0);

    // ---- PSLVERR only during wait cycles must be ignored ----
    PREADY  = 1'b0;
    PSLVERR = 1'b1;
    PRDATA  = 32'h0BAD_F00D;
    send_cmd(1'b0, 12'h104, 32'h0000_0000);
    chk_setup(1'b0, 12'h104, 32'h0000_0000);
    tick;
    tick;
    PREADY  = 1'b1;
    PSLVERR = 1'b0;
    tick;
    take_rsp(32'h0BAD_F00D, 1'b0, 1'b0);

    // ---- response back-pressure with a queued command ----
    PREADY = 1'b1;
    PRDATA = 32'hA5A5_0F0F;
    send_cmd(1'b0, 12'h020, 32'h0000_0000);
    chk_setup(1'b0, 12'h020, 32'h0000_0000);
    tick;
    PRDATA    = 32'h0000_0000;
    CMD_VALID = 1'b1;
    CMD_WRITE = 1'b1;
    CMD_ADDR  = 12'h010;
    CMD_WDATA = 32'h0000_0055;
    for (int i = 0; i < 10; i++) begin
      chk("bp_rspv",   {31'd0, RSP_VALID}, 32'd1);
      chk("bp_rdata",  RSP_RDATA,          32'hA5A5_0F0F);
      chk("bp_cmdrdy", {31'd0, CMD_READY}, 32'd0);
      chk("bp_psel",   {31'd0, PSEL},      32'd0);
      tick;
    end
    RSP_READY = 1'b1;
    tick;
    RSP_READY = 1'b0;
    chk("bp_done_rspv",   {31'd0, RSP_VALID}, 32'd0);
    chk("bp_done_cmdrdy", {31'd0, CMD_READY}, 32'd1);
    tick;
    CMD_VALID = 1'b0;
    chk_setup(1'b1, 12'h010, 32'h0000_0055);
    tick;
    take_rsp(32'h0000_0000, 1'b0, 1'b0);

    // ---- reset during the 2nd ACCESS wait cycle ----
    PREADY = 1'b0;
    PRDATA = 32'h7777_7777;
    send_cmd(1'b0, 12'h040, 32'h0000_0000);
    chk_setup(1'b0, 12'h040, 32'h0000_0000);
    tick;
    chk("mid_penable", {31'd0, PENABLE}, 32'd1);
    PRESET = 1'b1;
    #1;
    chk("mid_rst_cmdrdy", {31'd0, CMD_READY}, 32'd0);
    tick;
    chk("mid_rst_psel",    {31'd0, PSEL},      32'd0);
    chk("mid_rst_penable", {31'd0, PENABLE},   32'd0);
    chk("mid_rst_rspv",    {31'd0, RSP_VALID}, 32'd0);
    chk("mid_rst_busy",    {31'd0, BUSY},      32'd0);
    PRESET = 1'b0;
    PREADY = 1'b1;
    send_cmd(1'b1, 12'h008, 32'h0000_0077);
    chk_setup(1'b1, 12'h008, 32'h0000_0077);
    tick;
    take_rsp(32'h0000_0000, 1'b0, 1'b0);

`ifdef APB_TIMEOUT_EN
    // ---- watchdog: PREADY stuck low for 8 ACCESS cycles ----
    PREADY = 1'b0;
    PRDATA = 32'hCAFE_0001;
    send_cmd(1'b0, 12'h080, 32'h0000_0000);
    chk_setup(1'b0, 12'h080, 32'h0000_0000);
    for (int i = 0; i < 8; i++) begin
      chk("to_wait_penable", {31'd0, PENABLE},   32'd1);
      chk("to_wait_rspv",    {31'd0, RSP_VALID}, 32'd0);
      tick;
    end
    take_rsp(32'h0000_0000, 1'b1, 1'b1);

    // ---- PREADY on the 8th cycle wins over the watchdog ----
    PRDATA = 32'hCAFE_0002;
    send_cmd(1'b0, 12'h084, 32'h0000_0000);
    chk_setup(1'b0, 12'h084, 32'h0000_0000);
    for (int i = 0; i < 8; i++) begin
      chk("to_late_penable", {31'd0, PENABLE}, 32'd1);
      if (i == 7) PREADY = 1'b1;
      tick;
    end
    take_rsp(32'hCAFE_0002, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
